// File: rtl/aclk_pkg.sv
// Shared types, digit limits and load validation for the wall-clock time counter.
package aclk_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MAX_MS_HR      = 4'd2;
    localparam bcd_t MAX_LS_HR      = 4'd9;
    localparam bcd_t MAX_LS_HR_AT_2 = 4'd3;
    localparam bcd_t MAX_MS_MIN     = 4'd5;
    localparam bcd_t MAX_LS_MIN     = 4'd9;

    localparam int unsigned TICKS_PER_MIN_DEF = 60;

    // True when the four digits form a legal 24-hour HH:MM time.
    function automatic logic time_valid(input bcd_t ms_hr, input bcd_t ls_hr,
                                        input bcd_t ms_min, input bcd_t ls_min);
        logic hr_ok;
        if (ms_hr < MAX_MS_HR) begin
            hr_ok = (ls_hr <= MAX_LS_HR);
        end else if (ms_hr == MAX_MS_HR) begin
            hr_ok = (ls_hr <= MAX_LS_HR_AT_2);
        end else begin
            hr_ok = 1'b0;
        end
        return hr_ok && (ms_min <= MAX_MS_MIN) && (ls_min <= MAX_LS_MIN);
    endfunction

endpackage

// File: rtl/aclk_bcd_digit.sv
// Loadable BCD digit counter that wraps to zero after WRAP_VAL.
module aclk_bcd_digit
    import aclk_pkg::*;
#(
    parameter bcd_t WRAP_VAL = MAX_LS_MIN
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_en_i,
    input  logic load_i,
    input  bcd_t load_val_i,
    output bcd_t q_o,
    output logic carry_out_o
);

    bcd_t q_q, q_d;

    // Carry is combinational so a whole cascade settles in one cycle.
    assign carry_out_o = inc_en_i && (q_q == WRAP_VAL);
    assign q_o         = q_q;

    // Next digit value: load has priority over increment.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (inc_en_i) begin
            q_d = (q_q == WRAP_VAL) ? 4'd0 : q_q + 4'd1;
        end
    end

    // Digit register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/aclk_time_counter.sv
// 24-hour HH:MM BCD time counter with one-second tick prescaler and validated load.
module aclk_time_counter
    import aclk_pkg::*;
#(
    parameter int unsigned TICKS_PER_MIN = TICKS_PER_MIN_DEF,
    parameter int unsigned SEC_W         = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       fast_minute,
    input  logic       load_new_time,
    input  logic [3:0] key_ms_hr,
    input  logic [3:0] key_ls_hr,
    input  logic [3:0] key_ms_min,
    input  logic [3:0] key_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       minute_tick,
    output logic       day_wrap,
    output logic       load_err
);

    localparam logic [SEC_W-1:0] TickLast = SEC_W'(TICKS_PER_MIN - 1);

    logic [SEC_W-1:0] tick_q, tick_d;
    bcd_t             ms_hr_q, ms_hr_d, ls_hr_q, ls_hr_d;
    bcd_t             ms_min, ls_min;
    logic             key_ok, load_ok, load_bad;
    logic             min_inc, ls_carry, hr_inc, at_23;
    logic             minute_tick_q, day_wrap_q, load_err_q;

    assign key_ok   = time_valid(key_ms_hr, key_ls_hr, key_ms_min, key_ls_min);
    assign load_ok  = load_new_time && key_ok;
    assign load_bad = load_new_time && !key_ok;

    // A load of any kind swallows a coincident tick.
    assign min_inc  = one_second && !load_new_time && (fast_minute || (tick_q == TickLast));
    assign at_23    = (ms_hr_q == MAX_MS_HR) && (ls_hr_q == MAX_LS_HR_AT_2);

    // Tick prescaler next state.
    always_comb begin
        tick_d = tick_q;
        if (load_ok) begin
            tick_d = '0;
        end else if (one_second && !load_new_time) begin
            tick_d = min_inc ? '0 : tick_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    aclk_bcd_digit #(
        .WRAP_VAL (MAX_LS_MIN)
    ) u_ls_min (
        .clk_i       (clock),
        .rst_ni      (reset),
        .inc_en_i    (min_inc),
        .load_i      (load_ok),
        .load_val_i  (key_ls_min),
        .q_o         (ls_min),
        .carry_out_o (ls_carry)
    );

    aclk_bcd_digit #(
        .WRAP_VAL (MAX_MS_MIN)
    ) u_ms_min (
        .clk_i       (clock),
        .rst_ni      (reset),
        .inc_en_i    (ls_carry),
        .load_i      (load_ok),
        .load_val_i  (key_ms_min),
        .q_o         (ms_min),
        .carry_out_o (hr_inc)
    );

    // Hour pair next state: 23 rolls to 00, otherwise a plain two-digit BCD count.
    always_comb begin
        ms_hr_d = ms_hr_q;
        ls_hr_d = ls_hr_q;
        if (load_ok) begin
            ms_hr_d = key_ms_hr;
            ls_hr_d = key_ls_hr;
        end else if (hr_inc) begin
            if (at_23) begin
                ms_hr_d = 4'd0;
                ls_hr_d = 4'd0;
            end else if (ls_hr_q == MAX_LS_HR) begin
                ms_hr_d = ms_hr_q + 4'd1;
                ls_hr_d = 4'd0;
            end else begin
                ls_hr_d = ls_hr_q + 4'd1;
            end
        end
    end

    // Hour registers and registered status pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ms_hr_q       <= 4'd0;
            ls_hr_q       <= 4'd0;
            minute_tick_q <= 1'b0;
            day_wrap_q    <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            ms_hr_q       <= ms_hr_d;
            ls_hr_q       <= ls_hr_d;
            minute_tick_q <= min_inc;
            day_wrap_q    <= hr_inc && at_23;
            load_err_q    <= load_bad;
        end
    end

    assign current_time_ms_hr  = ms_hr_q;
    assign current_time_ls_hr  = ls_hr_q;
    assign current_time_ms_min = ms_min;
    assign current_time_ls_min = ls_min;
    assign minute_tick         = minute_tick_q;
    assign day_wrap            = day_wrap_q;
    assign load_err            = load_err_q;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Self-checking bench for aclk_time_counter against a minutes-of-day reference model.
module tb_aclk_time_counter;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        one_second = 1'b0;
    logic        fast_minute = 1'b0;
    logic        load_new_time = 1'b0;
    logic [15:0] key = 16'h0;
    logic [3:0]  c_ms_hr, c_ls_hr, c_ms_min, c_ls_min;
    logic        minute_tick, day_wrap, load_err;
    logic [15:0] dut_time;
    logic [2:0]  dut_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_min  = 0;
    int          m_tick = 0;
    logic [2:0]  m_pulse = 3'b000;  // {minute_tick, day_wrap, load_err}

    always #5 clock = ~clock;

    aclk_time_counter #(
        .TICKS_PER_MIN (T),
        .SEC_W         (3)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .one_second          (one_second),
        .fast_minute         (fast_minute),
        .load_new_time       (load_new_time),
        .key_ms_hr           (key[15:12]),
        .key_ls_hr           (key[11:8]),
        .key_ms_min          (key[7:4]),
        .key_ls_min          (key[3:0]),
        .current_time_ms_hr  (c_ms_hr),
        .current_time_ls_hr  (c_ls_hr),
        .current_time_ms_min (c_ms_min),
        .current_time_ls_min (c_ls_min),
        .minute_tick         (minute_tick),
        .day_wrap            (day_wrap),
        .load_err            (load_err)
    );

    assign dut_time  = {c_ms_hr, c_ls_hr, c_ms_min, c_ls_min};
    assign dut_pulse = {minute_tick, day_wrap, load_err};

    function automatic logic [15:0] to_bcd(input int m);
        int h, mi;
        h  = m / 60;
        mi = m % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
    endfunction

    // Apply one clock edge with the given inputs and advance the model.
    task automatic cycle(input logic rst_n, input logic os, input logic fm, input logic ld,
                         input logic [15:0] k);
        int hh, mm;
        reset = rst_n; one_second = os; fast_minute = fm; load_new_time = ld; key = k;
        @(posedge clock);
        hh = int'(k[15:12]) * 10 + int'(k[11:8]);
        mm = int'(k[7:4]) * 10 + int'(k[3:0]);
        m_pulse = 3'b000;
        if (!rst_n) begin
            m_min = 0; m_tick = 0;
        end else if (ld) begin
            if (k[15:12] <= 9 && k[11:8] <= 9 && k[7:4] <= 9 && k[3:0] <= 9
                && hh < 24 && mm < 60) begin
                m_min = hh * 60 + mm; m_tick = 0;
            end else begin
                m_pulse[0] = 1'b1;
            end
        end else if (os) begin
            if (fm || m_tick == T - 1) begin
                m_tick = 0;
                m_pulse[2] = 1'b1;
                m_pulse[1] = (m_min == 1439);
                m_min = (m_min + 1) % 1440;
            end else begin
                m_tick++;
            end
        end
        #1;
        reset = 1'b1; one_second = 1'b0; fast_minute = 1'b0; load_new_time = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if (dut_time !== 16'h0000) begin
            errors++; $display("FAIL reset_time got %h want 0000", dut_time);
        end
        checks++;
        if (dut_pulse !== 3'b000) begin
            errors++; $display("FAIL reset_pulse got %b want 000", dut_pulse);
        end
    endtask

    task automatic test_first_minute();
        int mt_cnt = 0;
        for (int i = 0; i < T; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
            if (minute_tick === 1'b1) mt_cnt++;
            checks++;
            if (dut_pulse !== m_pulse) begin
                errors++; $display("FAIL first_min_pulse got %b want %b", dut_pulse, m_pulse);
            end
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        end
        checks++;
        if (dut_time !== 16'h0001 || dut_time !== to_bcd(m_min)) begin
            errors++; $display("FAIL first_min_time got %h want 0001", dut_time);
        end
        checks++;
        if (mt_cnt != 1) begin
            errors++; $display("FAIL first_min_ticks got %0d want 1", mt_cnt);
        end
    endtask

    task automatic test_load_rollover();
        logic [15:0] start [2] = '{16'h1259, 16'h0959};
        logic [15:0] want  [2] = '{16'h1300, 16'h1000};
        for (int n = 0; n < 2; n++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, start[n]);
            checks++;
            if (dut_time !== start[n]) begin
                errors++; $display("FAIL load_time got %h want %h", dut_time, start[n]);
            end
            for (int i = 0; i < T; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
            checks++;
            if (dut_time !== want[n] || dut_time !== to_bcd(m_min)) begin
                errors++; $display("FAIL rollover_time got %h want %h", dut_time, want[n]);
            end
            checks++;
            if (dut_pulse !== 3'b100) begin
                errors++; $display("FAIL rollover_pulse got %b want 100", dut_pulse);
            end
        end
    endtask

    task automatic test_day_wrap();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h2359);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        checks++;
        if (dut_time !== 16'h0000) begin
            errors++; $display("FAIL day_wrap_time got %h want 0000", dut_time);
        end
        checks++;
        if (dut_pulse !== 3'b110) begin
            errors++; $display("FAIL day_wrap_pulse got %b want 110", dut_pulse);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if (dut_pulse !== 3'b000) begin
            errors++; $display("FAIL day_wrap_clear got %b want 000", dut_pulse);
        end
    endtask

    task automatic test_bad_load();
        logic [15:0] bad [3] = '{16'h2400, 16'h1960, 16'h2A00};
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0815);
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, bad[n]);
            checks++;
            if (dut_time !== 16'h0815) begin
                errors++; $display("FAIL bad_load_time got %h want 0815", dut_time);
            end
            checks++;
            if (dut_pulse !== 3'b001) begin
                errors++; $display("FAIL bad_load_err got %b want 001", dut_pulse);
            end
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
            checks++;
            if (load_err !== 1'b0) begin
                errors++; $display("FAIL bad_load_clear got %b want 0", load_err);
            end
        end
    endtask

    task automatic test_load_vs_tick();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < T - 1; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0730);
        checks++;
        if (dut_time !== 16'h0730 || dut_pulse !== 3'b000) begin
            errors++; $display("FAIL load_vs_tick got %h/%b want 0730/000", dut_time, dut_pulse);
        end
        // Prescaler must be cleared: only the T-th tick advances the minute.
        for (int i = 0; i < T; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
            checks++;
            if (minute_tick !== (i == T - 1)) begin
                errors++; $display("FAIL load_vs_tick_count i=%0d got %b want %b",
                                   i, minute_tick, (i == T - 1));
            end
        end
        // Held load with ticks keeps reloading and holds the prescaler at zero.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h1105);
        for (int i = 0; i < T - 1; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if (dut_time !== 16'h1105 || minute_tick !== 1'b0) begin
            errors++; $display("FAIL held_load got %h/%b want 1105/0", dut_time, minute_tick);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h1547);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if (dut_time !== 16'h0000 || dut_pulse !== 3'b000) begin
            errors++; $display("FAIL reset_mid got %h/%b want 0000/000", dut_time, dut_pulse);
        end
        for (int i = 0; i < T; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
            checks++;
            if (minute_tick !== (i == T - 1)) begin
                errors++; $display("FAIL reset_mid_count i=%0d got %b want %b",
                                   i, minute_tick, (i == T - 1));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] k;
        for (int i = 0; i < 600; i++) begin
            k = ($urandom_range(0, 1) == 0) ? to_bcd(int'($urandom_range(0, 1439)))
                                             : 16'($urandom);
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), k);
            checks++;
            if (dut_time !== to_bcd(m_min) || dut_pulse !== m_pulse) begin
                errors++; $display("FAIL random i=%0d got %h/%b want %h/%b",
                                   i, dut_time, dut_pulse, to_bcd(m_min), m_pulse);
            end
        end
        // Long run of ticks exercises carries across many hours and midnight.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h2250);
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b1, ($urandom_range(0, 1) == 0), 1'b0, 16'h0);
            checks++;
            if (dut_time !== to_bcd(m_min) || dut_pulse !== m_pulse) begin
                errors++; $display("FAIL run i=%0d got %h/%b want %h/%b",
                                   i, dut_time, dut_pulse, to_bcd(m_min), m_pulse);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_minute();
        test_load_rollover();
        test_day_wrap();
        test_bad_load();
        test_load_vs_tick();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aclk_time_counter.md
Name: aclk_time_counter

Overview:
Upstream timekeeping stage for the 4-digit LCD driver. Keeps current wall-clock time as four BCD digits, HH:MM, 24-hour format. Advances on a one-second enable tick and accepts a validated parallel load of a new time from the key register path. Its current_time_* outputs feed the current_time_* inputs of the LCD driver directly.

Parameters:
TICKS_PER_MIN, 60, number of one_second ticks per minute increment (bench may shrink it, e.g. 4)
SEC_W, 6, width of internal tick counter; must satisfy 2**SEC_W >= TICKS_PER_MIN

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clock
one_second  input  1  single-cycle enable pulse, once per second
fast_minute  input  1  test/set mode: each one_second tick advances one minute, not one second
load_new_time  input  1  single-cycle strobe; load key_* digits as new time
key_ms_hr  input  4  new time, tens of hours (BCD)
key_ls_hr  input  4  new time, units of hours (BCD)
key_ms_min  input  4  new time, tens of minutes (BCD)
key_ls_min  input  4  new time, units of minutes (BCD)
current_time_ms_hr  output  4  current tens of hours, 0-2
current_time_ls_hr  output  4  current units of hours, 0-9 (0-3 when ms_hr=2)
current_time_ms_min  output  4  current tens of minutes, 0-5
current_time_ls_min  output  4  current units of minutes, 0-9
minute_tick  output  1  one-cycle pulse in the cycle after the minute digits change by increment
day_wrap  output  1  one-cycle pulse when time wraps 23:59 -> 00:00
load_err  output  1  one-cycle pulse when a load strobe carries an invalid time

Behaviour:
- Reset (reset=0 at rising edge): all four digits = 0 (00:00). Tick counter = 0. minute_tick, day_wrap and load_err = 0. Reset overrides every other input.
- Tick counter: increments on one_second while fast_minute=0. When it reaches TICKS_PER_MIN-1 and another one_second arrives, it returns to 0 and the minute increment fires. Latency is 1 cycle: digits update on the edge that samples the tick.
- fast_minute=1: every one_second causes a minute increment and clears the tick counter.
- Minute increment cascade in BCD, all in one cycle:
  - ls_min 9->0 carries into ms_min.
  - ms_min 5->0 carries into hours.
  - Hours: ls_hr 9->0 with ms_hr+1. 23 -> 00 asserts day_wrap.
  - No digit ever holds a value outside its legal range.
- Load validity: ms_hr<=2; ls_hr<=9, or <=3 when ms_hr=2; ms_min<=5; ls_min<=9.
- Valid load: the four digits take the key values on the next edge and the tick counter clears.
- Invalid load: the digits and tick counter are left unchanged and load_err pulses on the next edge.
- load_new_time and one_second in the same cycle: load wins and the tick is discarded, so no minute_tick and no day_wrap.
- load_new_time held high for several cycles: it is re-evaluated every cycle, reloading the same value, and the tick counter stays at 0.
- minute_tick / day_wrap: registered pulses, high for exactly one cycle after the increment edge, never set by a load.
- one_second while reset=0: ignored, and no tick is remembered after reset is released.

Decomposition:
- Shared package aclk_pkg holds:
  - BCD digit type (4 bits);
  - digit limits: MAX_MS_HR=2, MAX_LS_HR=9, MAX_LS_HR_AT_2=3, MAX_MS_MIN=5, MAX_LS_MIN=9;
  - TICKS_PER_MIN default;
  - a validity function for a 4-digit time.
- One natural sub-module: aclk_bcd_digit.
  - Loadable, synchronous active-low reset, BCD counter with parameterised wrap value.
  - Inputs: inc_en and load.
  - Output: carry_out.
  - Instantiated for the two minute digits. The hour pair stays in the parent because of the 23 wrap.

Test Plan:
- Reset release, TICKS_PER_MIN=4, 4 one_second pulses -> digits 00:01, minute_tick pulses once, tick counter back to 0.
- Load 12:59 valid, then one full minute of ticks -> 13:00, one minute_tick, no day_wrap. Then load 09:59 and tick a minute -> 10:00.
- Load 23:59, fast_minute=1, one one_second -> 00:00, day_wrap=1 and minute_tick=1 for exactly one cycle.
- Load 24:00, 19:60 and 2A:00 (one strobe each) -> digits unchanged, load_err pulses once per strobe.
- load_new_time=1 (07:30) and one_second=1 in the same cycle, with the tick counter at TICKS_PER_MIN-1 -> 07:30, no minute_tick, tick counter 0.
- Reset asserted mid-count at 15:47 with one_second high -> next edge 00:00, all pulse outputs 0, first post-reset minute takes a full TICKS_PER_MIN ticks.
